// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage RISC-V pipeline: operand forwarding,
// load-use stalls, control-transfer flushes and stall/flush cycle counters.
module hazard_unit #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           RdD,
  input  logic                 RegWriteD,
  input  logic                 ResultSrcD,
  input  logic                 PCSrcE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  logic [4:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_e, load_e, reg_write_m, reg_write_w;
  logic       lw_stall;

  // Memory stage is checked first so the youngest producer wins.
  function automatic fwd_sel_e fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       rwm,
    input logic [4:0] rdw,
    input logic       rww
  );
    if (rwm && rdm != '0 && rdm == rs)      return FWD_MEM;
    else if (rww && rdw != '0 && rdw == rs) return FWD_WB;
    else                                    return FWD_RF;
  endfunction

  always_comb begin
    lw_stall  = load_e && (rd_e != '0) && ((rd_e == Rs1D) || (rd_e == Rs2D));
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!rst) begin
      StallF    = lw_stall && !PCSrcE;
      StallD    = lw_stall && !PCSrcE;
      FlushD    = PCSrcE;
      FlushE    = lw_stall || PCSrcE;
      ForwardAE = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      ForwardBE = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      load_e      <= 1'b0;
      rd_m        <= '0;
      reg_write_m <= 1'b0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else begin
      if (FlushE) begin
        rs1_e       <= '0;
        rs2_e       <= '0;
        rd_e        <= '0;
        reg_write_e <= 1'b0;
        load_e      <= 1'b0;
      end else begin
        rs1_e       <= Rs1D;
        rs2_e       <= Rs2D;
        rd_e        <= RdD;
        reg_write_e <= RegWriteD;
        load_e      <= ResultSrcD;
      end
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
    end
  end

  // Performance counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (StallD && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (PCSrcE && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end

endmodule
